// File: rtl/sprite_draw_scheduler.sv
// Frame-rate scheduler that shares one VGA pixel-write port between two sprites:
// each frame it erases every sprite's previous box and redraws it at the new position.
module sprite_draw_scheduler #(
  parameter int unsigned SIZE      = 4,
  parameter int unsigned WIDTH     = 160,
  parameter int unsigned HEIGHT    = 120,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic       iClock,
  input  logic       iResetn,
  input  logic       iFrameTick,
  input  logic [1:0] iEnable,
  input  logic [7:0] iX0,
  input  logic [6:0] iY0,
  input  logic [2:0] iColour0,
  input  logic [7:0] iX1,
  input  logic [6:0] iY1,
  input  logic [2:0] iColour1,
  output logic [7:0] oX,
  output logic [6:0] oY,
  output logic [2:0] oColour,
  output logic       oPlot,
  output logic       oBusy,
  output logic       oDone,
  output logic       oOverrun
);

  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned CW = 3;
  localparam int unsigned PW = 3;

  typedef enum logic [2:0] {IDLE, LATCH, ERASE, DRAW, NEXT, DONE} state_t;

  state_t          state, stateNext;
  logic            idx;
  logic            pending;
  logic [1:0]      oldValid, newEn;
  logic [XW-1:0]   oldX [2];
  logic [YW-1:0]   oldY [2];
  logic [XW-1:0]   newX [2];
  logic [YW-1:0]   newY [2];
  logic [CW-1:0]   newCol [2];
  logic [PW-1:0]   dx, dy;
  logic            lastPix;
  logic [XW-1:0]   baseX;
  logic [YW-1:0]   baseY;
  logic [XW:0]     xSum;
  logic [YW:0]     ySum;
  logic            inScreen;

  // Erase is skipped when there is no old box, draw when the sprite is disabled.
  function automatic state_t phaseEntry(input logic oldV, input logic en);
    if (oldV) return ERASE;
    if (en)   return DRAW;
    return NEXT;
  endfunction

  assign lastPix  = (dx == PW'(SIZE - 1)) && (dy == PW'(SIZE - 1));
  assign baseX    = (state == ERASE) ? oldX[idx] : newX[idx];
  assign baseY    = (state == ERASE) ? oldY[idx] : newY[idx];
  assign xSum     = {1'b0, baseX} + (XW + 1)'(dx);
  assign ySum     = {1'b0, baseY} + (YW + 1)'(dy);
  assign inScreen = (xSum < (XW + 1)'(WIDTH)) && (ySum < (YW + 1)'(HEIGHT));

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (iFrameTick) stateNext = LATCH;
      LATCH:   stateNext = phaseEntry(oldValid[0], iEnable[0]);
      ERASE:   if (lastPix) stateNext = newEn[idx] ? DRAW : NEXT;
      DRAW:    if (lastPix) stateNext = NEXT;
      NEXT:    stateNext = idx ? DONE : phaseEntry(oldValid[1], newEn[1]);
      DONE:    stateNext = (pending || iFrameTick) ? LATCH : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      state     <= IDLE;
      idx       <= 1'b0;
      pending   <= 1'b0;
      oldValid  <= '0;
      newEn     <= '0;
      oldX[0]   <= '0;
      oldX[1]   <= '0;
      oldY[0]   <= '0;
      oldY[1]   <= '0;
      newX[0]   <= '0;
      newX[1]   <= '0;
      newY[0]   <= '0;
      newY[1]   <= '0;
      newCol[0] <= '0;
      newCol[1] <= '0;
      dx        <= '0;
      dy        <= '0;
      oX        <= '0;
      oY        <= '0;
      oColour   <= '0;
      oPlot     <= 1'b0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      oOverrun  <= 1'b0;
    end else begin
      state    <= stateNext;
      oBusy    <= (stateNext != IDLE);
      oDone    <= (stateNext == DONE);
      oPlot    <= 1'b0;
      oOverrun <= 1'b0;

      // A tick during DONE is folded into the restart decision made this cycle.
      if (state == DONE) begin
        pending  <= pending && iFrameTick;
        oOverrun <= pending && iFrameTick;
      end else if (state != IDLE && iFrameTick) begin
        pending  <= 1'b1;
        oOverrun <= pending;
      end

      case (state)
        LATCH: begin
          newEn     <= iEnable;
          newX[0]   <= iX0;
          newY[0]   <= iY0;
          newCol[0] <= iColour0;
          newX[1]   <= iX1;
          newY[1]   <= iY1;
          newCol[1] <= iColour1;
          idx       <= 1'b0;
          dx        <= '0;
          dy        <= '0;
        end
        ERASE, DRAW: begin
          oX      <= xSum[XW-1:0];
          oY      <= ySum[YW-1:0];
          oColour <= (state == ERASE) ? BG_COLOUR : newCol[idx];
          oPlot   <= inScreen;
          // Row-major walk; clipped pixels still consume their cycle.
          if (lastPix) begin
            dx <= '0;
            dy <= '0;
          end else if (dx == PW'(SIZE - 1)) begin
            dx <= '0;
            dy <= dy + PW'(1);
          end else begin
            dx <= dx + PW'(1);
          end
        end
        NEXT: begin
          oldX[idx]     <= newX[idx];
          oldY[idx]     <= newY[idx];
          oldValid[idx] <= newEn[idx];
          idx           <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Self-checking bench for sprite_draw_scheduler against a per-frame pixel-list model.
module tb_sprite_draw_scheduler;

  localparam int SIZE   = 4;
  localparam int WIDTH  = 160;
  localparam int HEIGHT = 120;
  localparam int BG     = 0;

  logic       iClock = 1'b0;
  logic       iResetn = 1'b0;
  logic       iFrameTick = 1'b0;
  logic [1:0] iEnable = '0;
  logic [7:0] iX0 = '0, iX1 = '0;
  logic [6:0] iY0 = '0, iY1 = '0;
  logic [2:0] iColour0 = '0, iColour1 = '0;
  logic [7:0] oX;
  logic [6:0] oY;
  logic [2:0] oColour;
  logic       oPlot, oBusy, oDone, oOverrun;

  sprite_draw_scheduler #(
    .SIZE(SIZE), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BG_COLOUR(3'b000)
  ) dut (
    .iClock(iClock), .iResetn(iResetn), .iFrameTick(iFrameTick), .iEnable(iEnable),
    .iX0(iX0), .iY0(iY0), .iColour0(iColour0),
    .iX1(iX1), .iY1(iY1), .iColour1(iColour1),
    .oX(oX), .oY(oY), .oColour(oColour), .oPlot(oPlot),
    .oBusy(oBusy), .oDone(oDone), .oOverrun(oOverrun)
  );

  always #5 iClock = ~iClock;

  int total = 0;
  int bad = 0;
  int eX[$], eY[$], eC[$];
  int aX[$], aY[$], aC[$];
  int eCycles;
  bit mOldValid[2];
  int mOldX[2], mOldY[2];

  function automatic void modelReset();
    mOldValid[0] = 1'b0;
    mOldValid[1] = 1'b0;
  endfunction

  function automatic void addBox(input int bx, input int by, input int col);
    for (int dy = 0; dy < SIZE; dy++)
      for (int dx = 0; dx < SIZE; dx++)
        if (bx + dx < WIDTH && by + dy < HEIGHT) begin
          eX.push_back(bx + dx);
          eY.push_back(by + dy);
          eC.push_back(col);
        end
  endfunction

  // Expected visible pixels and frame length for the currently driven inputs.
  function automatic void modelFrame();
    int nx[2], ny[2], nc[2];
    nx[0] = int'(iX0); ny[0] = int'(iY0); nc[0] = int'(iColour0);
    nx[1] = int'(iX1); ny[1] = int'(iY1); nc[1] = int'(iColour1);
    eX.delete(); eY.delete(); eC.delete();
    eCycles = 2;
    for (int s = 0; s < 2; s++) begin
      if (mOldValid[s]) begin
        addBox(mOldX[s], mOldY[s], BG);
        eCycles += SIZE * SIZE;
      end
      if (iEnable[s]) begin
        addBox(nx[s], ny[s], nc[s]);
        eCycles += SIZE * SIZE;
      end
      eCycles += 1;
      mOldX[s] = nx[s];
      mOldY[s] = ny[s];
      mOldValid[s] = iEnable[s];
    end
  endfunction

  function automatic int plotDiff();
    int n = (aX.size() < eX.size()) ? aX.size() : eX.size();
    for (int i = 0; i < n; i++)
      if (aX[i] != eX[i] || aY[i] != eY[i] || aC[i] != eC[i]) return i;
    if (aX.size() != eX.size()) return n;
    return -1;
  endfunction

  task automatic drive(input logic [1:0] en, input int x0, input int y0, input int c0,
                       input int x1, input int y1, input int c1);
    iEnable = en;
    iX0 = 8'(x0); iY0 = 7'(y0); iColour0 = 3'(c0);
    iX1 = 8'(x1); iY1 = 7'(y1); iColour1 = 3'(c1);
  endtask

  // Leaves the bench at the negedge of the LATCH cycle.
  task automatic startFrame();
    @(negedge iClock);
    iFrameTick = 1'b1;
    @(negedge iClock);
    iFrameTick = 1'b0;
  endtask

  // Samples one frame from LATCH up to the oDone cycle, optionally injecting ticks.
  task automatic collect(input int tickA, input int tickB, input bit scramble,
                         output int cycles, output int firstPlot, output int overruns,
                         output bit timedOut);
    cycles = 0; firstPlot = -1; overruns = 0; timedOut = 1'b1;
    aX.delete(); aY.delete(); aC.delete();
    for (int i = 0; i < 300; i++) begin
      if (oBusy) cycles++;
      if (oOverrun) overruns++;
      if (oPlot) begin
        if (firstPlot < 0) firstPlot = i;
        aX.push_back(int'(oX));
        aY.push_back(int'(oY));
        aC.push_back(int'(oColour));
      end
      if (oDone) begin
        timedOut = 1'b0;
        break;
      end
      iFrameTick = (i == tickA || i == tickB);
      if (scramble && i == 1)
        drive(2'($urandom_range(0, 3)), int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 127)), int'($urandom_range(0, 7)));
      @(negedge iClock);
    end
    iFrameTick = 1'b0;
  endtask

  task automatic checkFrameAgainstModel(input string name, input int cycles, input bit timedOut);
    int d;
    total++;
    if (timedOut || cycles !== eCycles) begin
      bad++;
      $display("FAIL %s cycles: got %0d (timeout=%0d) want %0d", name, cycles, timedOut, eCycles);
    end
    d = plotDiff();
    total++;
    if (d != -1) begin
      bad++;
      $display("FAIL %s pixels: first diff at %0d, got %0d plots want %0d", name, d, aX.size(), eX.size());
    end
  endtask

  task automatic test_reset();
    iResetn = 1'b0;
    repeat (3) @(negedge iClock);
    total++;
    if ({oX, oY, oColour} !== 18'd0) begin
      bad++;
      $display("FAIL reset_pixel: got x=%0d y=%0d c=%0d want 0", oX, oY, oColour);
    end
    total++;
    if ({oPlot, oBusy, oDone, oOverrun} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0000", {oPlot, oBusy, oDone, oOverrun});
    end
    iResetn = 1'b1;
    modelReset();
  endtask

  task automatic test_first_frame();
    int cycles, firstPlot, ovr;
    bit to;
    drive(2'b11, 5, 5, 4, 20, 30, 2);
    modelFrame();
    startFrame();
    total++;
    if (oBusy !== 1'b1 || oPlot !== 1'b0) begin
      bad++;
      $display("FAIL latch_cycle: got busy=%b plot=%b want busy=1 plot=0", oBusy, oPlot);
    end
    collect(-1, -1, 1'b1, cycles, firstPlot, ovr, to);
    total++;
    if (cycles !== 36) begin
      bad++;
      $display("FAIL first_frame_len: got %0d want 36", cycles);
    end
    total++;
    if (firstPlot !== 2) begin
      bad++;
      $display("FAIL first_plot_latency: got %0d want 2", firstPlot);
    end
    total++;
    if (aX.size() !== 32) begin
      bad++;
      $display("FAIL first_frame_plots: got %0d want 32", aX.size());
    end
    checkFrameAgainstModel("first_frame", cycles, to);
  endtask

  task automatic test_move();
    int cycles, firstPlot, ovr;
    bit to;
    drive(2'b11, 6, 5, 4, 20, 30, 2);
    modelFrame();
    startFrame();
    collect(-1, -1, 1'b0, cycles, firstPlot, ovr, to);
    total++;
    if (cycles !== 68 || aX.size() !== 64) begin
      bad++;
      $display("FAIL move_frame: got cycles=%0d plots=%0d want 68/64", cycles, aX.size());
    end
    checkFrameAgainstModel("move", cycles, to);
  endtask

  task automatic test_clip();
    int cycles, firstPlot, ovr, corner;
    bit to;
    drive(2'b11, 158, 118, 5, 255, 10, 1);
    modelFrame();
    startFrame();
    collect(-1, -1, 1'b0, cycles, firstPlot, ovr, to);
    corner = 0;
    for (int i = 0; i < aX.size(); i++)
      if (aC[i] == 5) corner++;
    total++;
    if (corner !== 4 || cycles !== 68) begin
      bad++;
      $display("FAIL clip_corner: got plots=%0d cycles=%0d want 4/68", corner, cycles);
    end
    checkFrameAgainstModel("clip", cycles, to);
  endtask

  task automatic test_disable();
    int cycles, firstPlot, ovr;
    bit to;
    drive(2'b10, 40, 40, 3, 60, 60, 6);
    modelFrame();
    startFrame();
    collect(-1, -1, 1'b0, cycles, firstPlot, ovr, to);
    checkFrameAgainstModel("disable_erase", cycles, to);
    modelFrame();
    startFrame();
    collect(-1, -1, 1'b0, cycles, firstPlot, ovr, to);
    total++;
    if (cycles !== 36) begin
      bad++;
      $display("FAIL disable_quiet_len: got %0d want 36", cycles);
    end
    checkFrameAgainstModel("disable_quiet", cycles, to);
  endtask

  task automatic test_random();
    int cycles, firstPlot, ovr;
    bit to;
    for (int f = 0; f < 8; f++) begin
      drive(2'($urandom_range(0, 3)), int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 127)), int'($urandom_range(0, 7)));
      modelFrame();
      startFrame();
      collect(-1, -1, 1'b1, cycles, firstPlot, ovr, to);
      checkFrameAgainstModel("random", cycles, to);
    end
  endtask

  task automatic test_back_to_back();
    int cycles, firstPlot, ovr, ovr2, idleBusy;
    bit to;
    drive(2'b11, 10, 10, 1, 12, 12, 7);
    modelFrame();
    startFrame();
    collect(3, 10, 1'b0, cycles, firstPlot, ovr, to);
    checkFrameAgainstModel("b2b_first", cycles, to);
    @(negedge iClock);
    total++;
    if (oBusy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_no_idle: got busy=%b want 1", oBusy);
    end
    modelFrame();
    collect(-1, -1, 1'b0, cycles, firstPlot, ovr2, to);
    checkFrameAgainstModel("b2b_second", cycles, to);
    total++;
    if (ovr + ovr2 !== 1) begin
      bad++;
      $display("FAIL overrun_pulses: got %0d want 1", ovr + ovr2);
    end
    idleBusy = 0;
    repeat (6) begin
      @(negedge iClock);
      if (oBusy) idleBusy++;
    end
    total++;
    if (idleBusy !== 0) begin
      bad++;
      $display("FAIL single_extra_frame: got %0d busy cycles after second frame want 0", idleBusy);
    end
  endtask

  task automatic test_reset_mid_frame();
    int cycles, firstPlot, ovr;
    bit to;
    drive(2'b11, 30, 30, 5, 70, 70, 3);
    startFrame();
    repeat (20) @(negedge iClock);
    total++;
    if (oPlot !== 1'b1 || oBusy !== 1'b1) begin
      bad++;
      $display("FAIL mid_draw_active: got plot=%b busy=%b want 1/1", oPlot, oBusy);
    end
    iResetn = 1'b0;
    #1;
    total++;
    if (oPlot !== 1'b0 || oBusy !== 1'b0) begin
      bad++;
      $display("FAIL async_abort: got plot=%b busy=%b want 0/0", oPlot, oBusy);
    end
    @(negedge iClock);
    iResetn = 1'b1;
    modelReset();
    modelFrame();
    startFrame();
    collect(-1, -1, 1'b0, cycles, firstPlot, ovr, to);
    total++;
    if (cycles !== 36 || aX.size() !== 32) begin
      bad++;
      $display("FAIL post_reset_frame: got cycles=%0d plots=%0d want 36/32", cycles, aX.size());
    end
    checkFrameAgainstModel("post_reset", cycles, to);
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_move();
    test_clip();
    test_disable();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
